// File: rtl/pwm_duty_meter.sv
// Measures period and high time of an asynchronous PWM line and reports rounded duty in tenths.
// Optional 3-sample majority glitch filter: define PWM_METER_GLITCH_FILTER_EN.
module pwm_duty_meter #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic [3:0]       duty_step,
  output logic             meas_valid,
  output logic             stuck
);
  localparam int unsigned      DivW       = CNT_W + 4;
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {StSync, StHigh, StLow} state_e;

  logic sync1_q, sync2_q, s, s_d_q, rise, fall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_METER_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       maj_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q <= 2'b00;
      maj_q  <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], sync2_q};
      maj_q  <= (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end
  end

  assign s = maj_q;
`else
  assign s = sync2_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) s_d_q <= 1'b0;
    else        s_d_q <= s;
  end

  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

  // Measurement FSM
  state_e           state_q, state_d;
  logic [CNT_W-1:0] p_q, p_d, h_q, h_d;
  logic             reported_q, reported_d;
  logic             capture, tmo, tmo_high, p_at_max;

  assign p_at_max = (p_q == TimeoutCnt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StSync;
      p_q        <= '0;
      h_q        <= '0;
      reported_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      h_q        <= h_d;
      reported_q <= reported_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSync: if (rise) state_d = StHigh;
      StHigh: begin
        if (fall)          state_d = StLow;
        else if (p_at_max) state_d = StSync;
      end
      StLow: begin
        if (rise)          state_d = StHigh;
        else if (p_at_max) state_d = StSync;
      end
      default: state_d = StSync;
    endcase
  end

  always_comb begin
    p_d        = p_q + 1'b1;
    h_d        = h_q;
    reported_d = reported_q;
    capture    = 1'b0;
    tmo        = 1'b0;
    tmo_high   = s;
    unique case (state_q)
      StSync: begin
        if (rise) begin
          p_d        = CNT_W'(1);
          reported_d = 1'b0;
        end else if (p_at_max) begin
          p_d        = '0;
          tmo        = ~reported_q;
          reported_d = 1'b1;
        end
      end
      StHigh: begin
        if (fall) begin
          h_d = p_q;
        end else if (p_at_max) begin
          p_d        = '0;
          tmo        = 1'b1;
          tmo_high   = 1'b1;
          reported_d = 1'b1;
        end
      end
      StLow: begin
        if (rise) begin
          p_d     = CNT_W'(1);
          capture = 1'b1;
        end else if (p_at_max) begin
          p_d        = '0;
          tmo        = 1'b1;
          tmo_high   = 1'b0;
          reported_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Rounding divider: counts how many periods fit into 10*h + period/2
  logic             busy_q, step_ok, finish;
  logic [DivW-1:0]  acc_q, num_q, num_load;
  logic [CNT_W-1:0] per_q, hi_q;
  logic [3:0]       k_q;

  assign num_load = (DivW'(h_q) << 3) + (DivW'(h_q) << 1) + DivW'(p_q >> 1);
  assign step_ok  = (k_q < 4'd10) && ((acc_q + DivW'(per_q)) <= num_q);
  assign finish   = busy_q & ~step_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      acc_q  <= '0;
      num_q  <= '0;
      per_q  <= '0;
      hi_q   <= '0;
      k_q    <= '0;
    end else if (busy_q) begin
      if (step_ok) begin
        acc_q <= acc_q + DivW'(per_q);
        k_q   <= k_q + 4'd1;
      end else begin
        busy_q <= 1'b0;
      end
    end else if (capture) begin
      busy_q <= 1'b1;
      acc_q  <= '0;
      k_q    <= '0;
      num_q  <= num_load;
      per_q  <= p_q;
      hi_q   <= h_q;
    end
  end

  // Result registers; a timeout report overrides a divider finishing in the same cycle
  logic [CNT_W-1:0] period_d, high_d;
  logic [3:0]       duty_d;
  logic             stuck_d;

  always_comb begin
    period_d = period_cnt;
    high_d   = high_cnt;
    duty_d   = duty_step;
    stuck_d  = stuck;
    if (tmo) begin
      period_d = '0;
      high_d   = '0;
      duty_d   = tmo_high ? 4'd10 : 4'd0;
      stuck_d  = 1'b1;
    end else if (finish) begin
      period_d = per_q;
      high_d   = hi_q;
      duty_d   = k_q;
      stuck_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_cnt <= '0;
      high_cnt   <= '0;
      duty_step  <= '0;
      meas_valid <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      period_cnt <= period_d;
      high_cnt   <= high_d;
      duty_step  <= duty_d;
      meas_valid <= tmo | finish;
      stuck      <= stuck_d;
    end
  end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Randomized/directed bench for pwm_duty_meter: an edge-timestamp reference model fills a
// scoreboard queue while driving; a monitor pops and compares on every meas_valid.
module tb_pwm_duty_meter;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 1000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] period_cnt, high_cnt;
  logic [3:0]       duty_step;
  logic             meas_valid, stuck;

  pwm_duty_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_in    (pwm_in),
    .period_cnt(period_cnt),
    .high_cnt  (high_cnt),
    .duty_step (duty_step),
    .meas_valid(meas_valid),
    .stuck     (stuck)
  );

  always #5 clk = ~clk;

  typedef struct {
    int period;
    int high;
    int duty;
    int stk;
  } exp_t;

  exp_t exp_q[$];
  bit   lv[$];
  bit   ev[$];
  int   rst_at = -1;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic add(input bit l, input int n);
    for (int j = 0; j < n; j++) lv.push_back(l);
  endtask

  task automatic pwm(input int p, input int h, input int n);
    for (int j = 0; j < n; j++) begin
      add(1'b1, h);
      add(1'b0, p - h);
    end
  endtask

  // Reference model state: edge timestamps in sample indices
  int m_phase = 0;  // 0 waiting for rise, 1 high, 2 low
  int m_t_rise = 0;
  int m_h = 0;
  bit m_reported = 1'b0;
  int m_rst = -1;
  int m_cap_t = -1000;
  int m_cap_k = 0;
  bit m_prev = 1'b0;

  task automatic push_exp(input int p, input int h, input int d, input int s);
    exp_t e;
    e.period = p;
    e.high   = h;
    e.duty   = d;
    e.stk    = s;
    exp_q.push_back(e);
  endtask

  task automatic model_step(input int i);
    bit cur, r, f;
    int pp, k;
    cur = ev[i];
    if (i == rst_at) begin
      m_phase    = 0;
      m_reported = 1'b0;
      m_cap_t    = -1000;
      m_rst      = i;
      m_prev     = 1'b0;
      return;
    end
    r = cur & ~m_prev;
    f = ~cur & m_prev;
    case (m_phase)
      0: begin
        if (r) begin
          m_phase    = 1;
          m_t_rise   = i;
          m_reported = 1'b0;
        end else if (!m_reported && i == m_rst + int'(TIMEOUT) - 1) begin
          push_exp(0, 0, cur ? 10 : 0, 1);
          m_reported = 1'b1;
        end
      end
      1: begin
        if (f) begin
          m_phase = 2;
          m_h     = i - m_t_rise;
        end else if (i - m_t_rise == int'(TIMEOUT)) begin
          push_exp(0, 0, 10, 1);
          m_phase    = 0;
          m_reported = 1'b1;
        end
      end
      default: begin
        if (r) begin
          pp = i - m_t_rise;
          // Divider is busy for k+1 cycles after a capture; later captures are dropped
          if (i >= m_cap_t + m_cap_k + 2) begin
            k = (10 * m_h + pp / 2) / pp;
            if (k > 10) k = 10;
            push_exp(pp, m_h, k, 0);
            m_cap_t = i;
            m_cap_k = k;
          end
          m_t_rise = i;
          m_phase  = 1;
        end else if (i - m_t_rise == int'(TIMEOUT)) begin
          push_exp(0, 0, 0, 1);
          m_phase    = 0;
          m_reported = 1'b1;
        end
      end
    endcase
    m_prev = cur;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (meas_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_meas_valid: period=%0d high=%0d duty=%0d stuck=%0d at %0t",
                 period_cnt, high_cnt, duty_step, stuck, $time);
      end else begin
        e = exp_q.pop_front();
        check("period_cnt", period_cnt, e.period);
        check("high_cnt", high_cnt, e.high);
        check("duty_step", duty_step, e.duty);
        check("stuck", stuck, e.stk);
      end
    end
  end

  initial begin
    int p, h;
    add(1'b0, 20);
    pwm(10, 5, 8);
    pwm(10, 3, 4);
    pwm(10, 8, 4);
    pwm(4, 1, 6);
    pwm(20, 1, 3);
    pwm(30, 1, 3);
    for (int j = 0; j < 20; j++) begin
      p = int'($urandom_range(12, 200));
      h = int'($urandom_range(2, p - 2));
      pwm(p, h, 1);
    end
    add(1'b1, 1500);
    add(1'b0, 1500);
    pwm(13, 5, 3);
    add(1'b0, 1500);
    pwm(10, 5, 4);
    pwm(12, 6, 2);
    rst_at = lv.size() + 20;
    add(1'b1, 30);
    add(1'b0, 7);
    pwm(10, 5, 3);
    pwm(10, 5, 2);
    add(1'b1, 5);
    add(1'b0, 2);
    add(1'b1, 1);
    add(1'b0, 2);
    pwm(10, 5, 3);
    add(1'b0, 60);

    foreach (lv[j]) ev.push_back(lv[j]);
`ifdef PWM_METER_GLITCH_FILTER_EN
    for (int j = 1; j < lv.size() - 1; j++)
      if (lv[j] != lv[j-1] && lv[j] != lv[j+1]) ev[j] = lv[j-1];
`endif

    repeat (3) @(negedge clk);
    check("reset_period_cnt", period_cnt, 0);
    check("reset_high_cnt", high_cnt, 0);
    check("reset_duty_step", duty_step, 0);
    check("reset_meas_valid", meas_valid, 0);
    check("reset_stuck", stuck, 0);

    for (int i = 0; i < lv.size(); i++) begin
      @(negedge clk);
      if (i == rst_at + 1) begin
        check("midrst_period_cnt", period_cnt, 0);
        check("midrst_high_cnt", high_cnt, 0);
        check("midrst_duty_step", duty_step, 0);
        check("midrst_meas_valid", meas_valid, 0);
        check("midrst_stuck", stuck, 0);
      end
      pwm_in = lv[i];
      rst_n  = (i != rst_at);
      model_step(i);
    end

    repeat (30) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_meas_valid: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
